// File: rtl/sram_fifo_pkg.sv
// Shared definitions for the SRAM FIFO packer/unpacker pair: FIFO entry layout,
// byte geometry of the payload chunks and the AXI4-Stream beat record.
package sram_fifo_pkg;

   localparam int TDATA_BYTES   = 32;
   localparam int CROPPED_BYTES = 24;
   localparam int TUSER_W       = 128;
   localparam int PAYLOAD_W     = 8*CROPPED_BYTES;

   // Entry layout, LSB first: {payload, nbytes, phase, eop, vld}
   localparam int VLD_BIT     = 0;
   localparam int EOP_BIT     = 1;
   localparam int PHASE_LSB   = 2;
   localparam int PHASE_W     = 2;
   localparam int NBYTES_LSB  = 4;
   localparam int NBYTES_W    = 5;
   localparam int PAYLOAD_LSB = 9;
   localparam int FIFO_W      = PAYLOAD_LSB + PAYLOAD_W;

   // One full beat plus one chunk: worst case residue (31) + chunk (24) fits.
   localparam int RES_BYTES = TDATA_BYTES + CROPPED_BYTES;

   typedef struct packed {
      logic [8*TDATA_BYTES-1:0] data;
      logic [TDATA_BYTES-1:0]   keep;
      logic                     last;
      logic [TUSER_W-1:0]       user;
   } axis_beat_t;

   function automatic logic [TDATA_BYTES-1:0] low_mask(input logic [5:0] n);
      low_mask = ~({TDATA_BYTES{1'b1}} << n);
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output holding register: the beat stays stable
// while valid is high and ready is low.
module axis_out_reg
   import sram_fifo_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  axis_beat_t beat_i,
   input  logic       ready_i,
   output logic       valid_o,
   output axis_beat_t beat_o,
   output logic       free_o
);

   logic       valid_q;
   axis_beat_t beat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         beat_q  <= beat_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   // Loadable when empty or when the current beat is being accepted.
   assign free_o  = ~valid_q | ready_i;
   assign valid_o = valid_q;
   assign beat_o  = beat_q;

endmodule

// File: rtl/fifo_to_axi_unpacker.sv
// Pops packed 24-byte chunks from the async FIFO read port and regroups them
// into 32-byte AXI4-Stream beats, with phase checking and credit return.
module fifo_to_axi_unpacker
   import sram_fifo_pkg::*;
#(
   parameter int TDATA_WIDTH         = TDATA_BYTES,
   parameter int CROPPED_TDATA_WIDTH = CROPPED_BYTES,
   parameter int TUSER_WIDTH         = TUSER_W,
   parameter int FIFO_WIDTH          = FIFO_W
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [FIFO_WIDTH-1:0]    fifo_dout,
   input  logic                     fifo_rempty,
   output logic                     fifo_rinc,
   output logic                     tvalid,
   input  logic                     tready,
   output logic [8*TDATA_WIDTH-1:0] tdata,
   output logic [TDATA_WIDTH-1:0]   tkeep,
   output logic [TDATA_WIDTH-1:0]   tstrb,
   output logic                     tlast,
   output logic [TUSER_WIDTH-1:0]   tuser,
   input  logic [TUSER_WIDTH-1:0]   tuser_cfg,
   output logic                     output_inc,
   output logic [31:0]              pkt_cnt,
   output logic                     phase_err
);

   localparam int RES_W  = 8*RES_BYTES;
   localparam int BEAT_W = 8*TDATA_BYTES;

   logic [RES_W-1:0]    res_q, res_d;
   logic [5:0]          r_q, r_d;
   logic [PHASE_W-1:0]  exp_phase_q, exp_phase_d;
   logic                pend_q, pend_d;
   logic                err_q, err_d;
   logic                first_q, first_d;
   logic [TUSER_W-1:0]  user_q, user_d;
   logic [31:0]         pkt_cnt_q, pkt_cnt_d;

   logic                e_vld, e_eop, nb_over;
   logic [PHASE_W-1:0]  e_phase;
   logic [NBYTES_W-1:0] e_nbytes, nb;
   logic [PAYLOAD_W-1:0] e_payload, pay_m;
   logic [RES_W-1:0]    merged;
   logic [5:0]          total;
   logic                pop, flush, load, free, out_valid;
   axis_beat_t          beat, out_beat;

   assign e_vld     = fifo_dout[VLD_BIT];
   assign e_eop     = fifo_dout[EOP_BIT];
   assign e_phase   = fifo_dout[PHASE_LSB +: PHASE_W];
   assign e_nbytes  = fifo_dout[NBYTES_LSB +: NBYTES_W];
   assign e_payload = fifo_dout[PAYLOAD_LSB +: PAYLOAD_W];

   assign nb_over = e_nbytes > NBYTES_W'(CROPPED_BYTES);
   assign nb      = nb_over ? NBYTES_W'(CROPPED_BYTES) : e_nbytes;

   // Bytes past nbytes are zeroed so the residue stays clean above R.
   always_comb begin
      pay_m = '0;
      for (int i = 0; i < CROPPED_BYTES; i++)
         if (i < int'(nb)) pay_m[8*i +: 8] = e_payload[8*i +: 8];
   end

   assign merged = res_q | ({{(RES_W-PAYLOAD_W){1'b0}}, pay_m} << {r_q, 3'b000});
   assign total  = r_q + {1'b0, nb};

   // A pending tail beat owns the output register for one slot; no pop then.
   assign pop   = ~fifo_rempty & free & ~pend_q;
   assign flush = pend_q & free;

   always_comb begin
      res_d       = res_q;
      r_d         = r_q;
      exp_phase_d = exp_phase_q;
      pend_d      = pend_q;
      err_d       = err_q;
      first_d     = first_q;
      user_d      = user_q;
      pkt_cnt_d   = pkt_cnt_q;
      load        = 1'b0;
      beat        = '0;
      beat.user   = first_q ? tuser_cfg : user_q;

      if (flush) begin
         load      = 1'b1;
         beat.data = res_q[BEAT_W-1:0];
         beat.keep = low_mask(r_q);
         beat.last = 1'b1;
         res_d     = '0;
         r_d       = '0;
         pend_d    = 1'b0;
      end else if (pop && e_vld) begin
         if (nb_over) err_d = 1'b1;
         if (e_phase != exp_phase_q) begin
            err_d       = 1'b1;
            exp_phase_d = e_phase + 2'd1;
         end else begin
            exp_phase_d = exp_phase_q + 2'd1;
         end
         if (e_eop) exp_phase_d = '0;

         if (total >= 6'd32) begin
            load      = 1'b1;
            beat.data = merged[BEAT_W-1:0];
            beat.keep = '1;
            beat.last = e_eop && (total == 6'd32);
            pend_d    = e_eop && (total != 6'd32);
            res_d     = merged >> BEAT_W;
            r_d       = total - 6'd32;
         end else if (e_eop) begin
            load      = 1'b1;
            beat.data = merged[BEAT_W-1:0];
            beat.keep = low_mask(total);
            beat.last = 1'b1;
            res_d     = '0;
            r_d       = '0;
         end else begin
            res_d = merged;
            r_d   = total;
         end
      end

      if (load) begin
         first_d = beat.last;
         if (first_q) user_d = tuser_cfg;
      end

      if (out_valid && tready && out_beat.last) pkt_cnt_d = pkt_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         res_q       <= '0;
         r_q         <= '0;
         exp_phase_q <= '0;
         pend_q      <= 1'b0;
         err_q       <= 1'b0;
         first_q     <= 1'b1;
         user_q      <= '0;
         pkt_cnt_q   <= '0;
      end else begin
         res_q       <= res_d;
         r_q         <= r_d;
         exp_phase_q <= exp_phase_d;
         pend_q      <= pend_d;
         err_q       <= err_d;
         first_q     <= first_d;
         user_q      <= user_d;
         pkt_cnt_q   <= pkt_cnt_d;
      end
   end

   axis_out_reg u_out (
      .clk     (clk),
      .rst_n   (resetn),
      .load_i  (load),
      .beat_i  (beat),
      .ready_i (tready),
      .valid_o (out_valid),
      .beat_o  (out_beat),
      .free_o  (free)
   );

   assign tvalid     = out_valid;
   assign tdata      = out_beat.data;
   assign tkeep      = out_beat.keep;
   assign tstrb      = out_beat.keep;
   assign tlast      = out_beat.last;
   assign tuser      = out_beat.user;
   assign fifo_rinc  = pop;
   assign output_inc = pop;
   assign pkt_cnt    = pkt_cnt_q;
   assign phase_err  = err_q;

endmodule

// File: tb/tb_fifo_to_axi_unpacker.sv
// Scoreboard bench for fifo_to_axi_unpacker: directed packets are queued as
// expected beats; a negedge monitor compares every accepted beat.
module tb_fifo_to_axi_unpacker;

   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         last;
      logic [127:0] user;
   } beat_t;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [200:0] fifo_dout = '0;
   logic         fifo_rempty = 1'b1;
   logic         fifo_rinc;
   logic         tvalid;
   logic         tready = 1'b0;
   logic [255:0] tdata;
   logic [31:0]  tkeep, tstrb;
   logic         tlast;
   logic [127:0] tuser;
   logic [127:0] tuser_cfg = '0;
   logic         output_inc;
   logic [31:0]  pkt_cnt;
   logic         phase_err;

   beat_t        exp_q[$];
   logic [200:0] fq[$];
   int           n_checks = 0;
   int           n_errs = 0;
   int           inc_cnt = 0;

   always #5 clk = ~clk;

   fifo_to_axi_unpacker dut (
      .clk(clk), .resetn(resetn), .fifo_dout(fifo_dout), .fifo_rempty(fifo_rempty),
      .fifo_rinc(fifo_rinc), .tvalid(tvalid), .tready(tready), .tdata(tdata),
      .tkeep(tkeep), .tstrb(tstrb), .tlast(tlast), .tuser(tuser), .tuser_cfg(tuser_cfg),
      .output_inc(output_inc), .pkt_cnt(pkt_cnt), .phase_err(phase_err)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [255:0] bmask(input logic [31:0] k);
      logic [255:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   // Payload byte i = start+i for i<nb; bytes past nb carry junk.
   function automatic logic [200:0] mk_entry(input logic [7:0] start, input int nb,
                                             input logic [1:0] ph, input logic eop, input logic vld);
      logic [191:0] pay;
      for (int i = 0; i < 24; i++) pay[8*i +: 8] = (i < nb) ? 8'(start + i) : 8'hEE;
      return {pay, 5'(nb), ph, eop, vld};
   endfunction

   task automatic refresh();
      fifo_rempty = (fq.size() == 0);
      fifo_dout   = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic push(input logic [200:0] e);
      fq.push_back(e);
      refresh();
   endtask

   // FWFT FIFO model: the pop decision is sampled mid-cycle, applied after the edge.
   task automatic tick();
      logic popped;
      @(negedge clk);
      popped = fifo_rinc;
      @(posedge clk);
      #1;
      if (popped && fq.size() != 0) void'(fq.pop_front());
      refresh();
   endtask

   // Packet bytes are base, base+1, ... split into 32-byte beats.
   task automatic expect_pkt(input logic [7:0] base, input int len, input logic [127:0] user);
      for (int j = 0; j * 32 < len; j++) begin
         beat_t b;
         int n;
         n = (len - 32*j >= 32) ? 32 : len - 32*j;
         b = '0;
         for (int i = 0; i < n; i++) b.data[8*i +: 8] = 8'(base + 32*j + i);
         b.keep = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
         b.last = (32*(j+1) >= len);
         b.user = user;
         exp_q.push_back(b);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((fq.size() != 0 || exp_q.size() != 0 || tvalid) && k < 300) begin
         tick();
         k++;
      end
      n_checks++;
      if (k >= 300) begin
         n_errs++;
         $display("FAIL drain_timeout: fifo %0d expected_beats %0d tvalid %0b", fq.size(), exp_q.size(), tvalid);
      end
   endtask

   // Monitor: beat scoreboard, hold-stable rule, credit pulse accounting.
   initial begin
      beat_t hold, e;
      logic  stalled;
      logic [255:0] m;
      stalled = 1'b0;
      hold = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            stalled = 1'b0;
         end else begin
            chk("output_inc_eq_rinc", 256'(output_inc), 256'(fifo_rinc));
            if (output_inc) inc_cnt++;
            if (stalled) begin
               chk("hold_valid", 256'(tvalid), 256'(1));
               chk("hold_data", tdata, hold.data);
               chk("hold_keep", 256'(tkeep), 256'(hold.keep));
               chk("hold_last", 256'(tlast), 256'(hold.last));
               chk("hold_user", 256'(tuser), 256'(hold.user));
            end
            if (tvalid && tready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errs++;
                  $display("FAIL unexpected_beat: got data %0h keep %0h, expected no beat", tdata, tkeep);
               end else begin
                  e = exp_q.pop_front();
                  m = bmask(e.keep);
                  chk("beat_data", tdata & m, e.data & m);
                  chk("beat_keep", 256'(tkeep), 256'(e.keep));
                  chk("beat_strb", 256'(tstrb), 256'(e.keep));
                  chk("beat_last", 256'(tlast), 256'(e.last));
                  chk("beat_user", 256'(tuser), 256'(e.user));
               end
            end
            stalled   = tvalid && !tready;
            hold.data = tdata;
            hold.keep = tkeep;
            hold.last = tlast;
            hold.user = tuser;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int i0, k;
      refresh();
      repeat (3) tick();
      chk("rst_tvalid", 256'(tvalid), 256'(0));
      chk("rst_tlast", 256'(tlast), 256'(0));
      chk("rst_tdata", tdata, 256'(0));
      chk("rst_tkeep", 256'(tkeep), 256'(0));
      chk("rst_tstrb", 256'(tstrb), 256'(0));
      chk("rst_tuser", 256'(tuser), 256'(0));
      chk("rst_rinc", 256'(fifo_rinc), 256'(0));
      chk("rst_pkt_cnt", 256'(pkt_cnt), 256'(0));
      chk("rst_phase_err", 256'(phase_err), 256'(0));
      resetn = 1'b1;
      tready = 1'b1;
      tick();

      // 96-byte packet, 4 full chunks; cfg changes after the first beat loads
      tuser_cfg = 128'hA1A1_0000_0000_0000_0000_0000_0000_00A1;
      i0 = inc_cnt;
      expect_pkt(8'h10, 96, 128'hA1A1_0000_0000_0000_0000_0000_0000_00A1);
      push(mk_entry(8'h10, 24, 2'd0, 1'b0, 1'b1));
      push(mk_entry(8'h28, 24, 2'd1, 1'b0, 1'b1));
      push(mk_entry(8'h40, 24, 2'd2, 1'b0, 1'b1));
      push(mk_entry(8'h58, 24, 2'd3, 1'b1, 1'b1));
      tick();
      tick();
      tuser_cfg = 128'hDEAD;
      drain();
      chk("t1_pkt_cnt", 256'(pkt_cnt), 256'(1));
      chk("t1_inc_pulses", 256'(inc_cnt - i0), 256'(4));
      chk("t1_phase_err", 256'(phase_err), 256'(0));

      // 48-byte packet then a queued 10-byte packet: no pop while the tail beat loads
      tuser_cfg = 128'hB2;
      i0 = inc_cnt;
      expect_pkt(8'h80, 48, 128'hB2);
      expect_pkt(8'hC0, 10, 128'hB2);
      push(mk_entry(8'h80, 24, 2'd0, 1'b0, 1'b1));
      push(mk_entry(8'h98, 24, 2'd1, 1'b1, 1'b1));
      push(mk_entry(8'hC0, 10, 2'd0, 1'b1, 1'b1));
      k = 0;
      while (!(tvalid && !tlast) && k < 20) begin
         tick();
         k++;
      end
      chk("t2_beat1_seen", 256'(k < 20), 256'(1));
      chk("t2_rinc_tail_load", 256'(fifo_rinc), 256'(0));
      drain();
      chk("t2_pkt_cnt", 256'(pkt_cnt), 256'(3));
      chk("t2_inc_pulses", 256'(inc_cnt - i0), 256'(3));

      // 10-byte packet: one-cycle latency, partial keep, tuser latched at load
      tuser_cfg = 128'hC3C3;
      expect_pkt(8'h33, 10, 128'hC3C3);
      push(mk_entry(8'h33, 10, 2'd0, 1'b1, 1'b1));
      tick();
      chk("t3_latency_tvalid", 256'(tvalid), 256'(1));
      chk("t3_tkeep", 256'(tkeep), 256'(32'h0000_03FF));
      chk("t3_tlast", 256'(tlast), 256'(1));
      chk("t3_tuser", 256'(tuser), 256'(128'hC3C3));
      tuser_cfg = '0;
      drain();
      chk("t3_pkt_cnt", 256'(pkt_cnt), 256'(4));

      // Backpressure for 5 cycles with FIFO non-empty
      tready = 1'b0;
      tuser_cfg = 128'hD4;
      expect_pkt(8'h50, 72, 128'hD4);
      push(mk_entry(8'h50, 24, 2'd0, 1'b0, 1'b1));
      push(mk_entry(8'h68, 24, 2'd1, 1'b0, 1'b1));
      push(mk_entry(8'h80, 24, 2'd2, 1'b1, 1'b1));
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("t4_rinc_stalled", 256'(fifo_rinc), 256'(0));
         chk("t4_tvalid_stalled", 256'(tvalid), 256'(1));
      end
      tready = 1'b1;
      drain();
      chk("t4_pkt_cnt", 256'(pkt_cnt), 256'(5));
      chk("t4_phase_err", 256'(phase_err), 256'(0));

      // Phase mismatch plus a vld=0 entry; then a clean packet (error is sticky)
      tuser_cfg = 128'hE5;
      i0 = inc_cnt;
      expect_pkt(8'h00, 56, 128'hE5);
      push(mk_entry(8'h00, 24, 2'd0, 1'b0, 1'b1));
      push(mk_entry(8'h77, 20, 2'd3, 1'b0, 1'b0));
      push(mk_entry(8'h18, 24, 2'd2, 1'b0, 1'b1));
      push(mk_entry(8'h30, 8, 2'd3, 1'b1, 1'b1));
      drain();
      chk("t5_phase_err", 256'(phase_err), 256'(1));
      chk("t5_inc_pulses", 256'(inc_cnt - i0), 256'(4));
      chk("t5_pkt_cnt", 256'(pkt_cnt), 256'(6));
      expect_pkt(8'h40, 32, 128'hE5);
      push(mk_entry(8'h40, 24, 2'd0, 1'b0, 1'b1));
      push(mk_entry(8'h58, 8, 2'd1, 1'b1, 1'b1));
      drain();
      chk("t5_phase_err_sticky", 256'(phase_err), 256'(1));
      chk("t5_pkt_cnt2", 256'(pkt_cnt), 256'(7));

      // Reset mid-packet with 16 residue bytes, then a fresh 32-byte packet
      tready = 1'b0;
      push(mk_entry(8'h90, 24, 2'd0, 1'b0, 1'b1));
      push(mk_entry(8'hA8, 24, 2'd1, 1'b0, 1'b1));
      tick();
      tick();
      tick();
      chk("t6_pre_reset_tvalid", 256'(tvalid), 256'(1));
      resetn = 1'b0;
      #1;
      chk("t6_reset_tvalid", 256'(tvalid), 256'(0));
      chk("t6_reset_pkt_cnt", 256'(pkt_cnt), 256'(0));
      chk("t6_reset_phase_err", 256'(phase_err), 256'(0));
      fq.delete();
      exp_q.delete();
      refresh();
      tick();
      tick();
      resetn = 1'b1;
      tready = 1'b1;
      tuser_cfg = 128'hF6;
      expect_pkt(8'hB0, 32, 128'hF6);
      push(mk_entry(8'hB0, 24, 2'd0, 1'b0, 1'b1));
      push(mk_entry(8'hC8, 8, 2'd1, 1'b1, 1'b1));
      drain();
      chk("t6_pkt_cnt", 256'(pkt_cnt), 256'(1));
      chk("t6_phase_err", 256'(phase_err), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
